set_multi_count: RTL and testbench

//  Parametrised successor of the 3-circle lattice counter. Counts points (x,y), x,y in 1..GRID,

---
 rtl/set_multi_pkg.sv | 32 +++
 rtl/set_circle_hit.sv | 37 +++
 rtl/set_multi_count.sv | 162 ++++++++++++++++
 tb/tb_set_multi_count.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_multi_pkg.sv
// Shared types for the multi-circle lattice counter.
// Holds the combine-mode and FSM-state encodings, plus a popcount helper.
package set_multi_pkg;

  // Widest hit vector the popcount helper handles.
  localparam int MAX_SETS = 32;

  typedef enum logic [2:0] {
    MODE_SINGLE      = 3'd0,
    MODE_ALL         = 3'd1,
    MODE_ANY         = 3'd2,
    MODE_EXACTLY_ONE = 3'd3,
    MODE_ODD         = 3'd4
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  function automatic int unsigned popcount(input logic [MAX_SETS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_SETS; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/set_circle_hit.sv
// Combinational point-in-circle test: hit = dx^2 + dy^2 <= r^2.
// dx/dy are absolute differences. Both are CW bits wide, because the centre
// field is CW bits and so the difference always fits.
module set_circle_hit #(
  parameter int CW = 4,
  parameter int RW = 4
) (
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  input  logic [RW-1:0] r,
  output logic          hit
);

  // Common comparison width, wide enough for both the distance sum and r^2.
  localparam int SW = (2*CW+1 > 2*RW) ? 2*CW+1 : 2*RW;

  logic [CW-1:0]   dx;
  logic [CW-1:0]   dy;
  logic [2*CW-1:0] sx;
  logic [2*CW-1:0] sy;
  logic [2*CW:0]   d2;
  logic [2*RW-1:0] r2;

  // Squared distance from the centre versus squared radius, both zero-extended.
  always_comb begin
    dx  = (px >= cx) ? px - cx : cx - px;
    dy  = (py >= cy) ? py - cy : cy - py;
    sx  = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
    sy  = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
    d2  = {1'b0, sx} + {1'b0, sy};
    r2  = {{RW{1'b0}}, r} * {{RW{1'b0}}, r};
    hit = SW'(d2) <= SW'(r2);
  end

endmodule

// File: rtl/set_multi_count.sv
// Counts lattice points (x,y), x,y in 1..GRID, that fall inside a Boolean
// combination of NUM_SETS circles. It tests one point per cycle against all
// circles in parallel.
// Pipeline: scan counters -> stage1 hit vector -> stage2 accumulate.
// Optional build macro SET_HIT_STREAM_EN adds the hit_valid/hit_x/hit_y
// outputs, which report each point at the moment it is counted.
module set_multi_count
  import set_multi_pkg::*;
#(
  parameter  int NUM_SETS = 3,
  parameter  int GRID     = 8,
  parameter  int RW       = 4,
  localparam int CW       = $clog2(GRID + 1),
  localparam int KW       = $clog2(GRID * GRID + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_SETS*2*CW-1:0] central,
  input  logic [NUM_SETS*RW-1:0]   radius,
  input  logic [NUM_SETS-1:0]      set_mask,
  input  logic [2:0]               mode,
`ifdef SET_HIT_STREAM_EN
  output logic                     hit_valid,
  output logic [CW-1:0]            hit_x,
  output logic [CW-1:0]            hit_y,
`endif
  output logic                     busy,
  output logic                     valid,
  output logic [KW-1:0]            candidate
);

  state_e                   state;
  logic [NUM_SETS*2*CW-1:0] central_q;
  logic [NUM_SETS*RW-1:0]   radius_q;
  logic [NUM_SETS-1:0]      mask_q;
  logic [2:0]               mode_q;
  logic [CW-1:0]            x_s;
  logic [CW-1:0]            y_s;
  logic [NUM_SETS-1:0]      hit;
  logic [NUM_SETS-1:0]      h_q;
  logic                     h_valid;
  logic                     count_hit;
  logic                     last_point;

  // One circle tester per set. All of them look at the current scan point.
  for (genvar i = 0; i < NUM_SETS; i++) begin : g_circle
    set_circle_hit #(.CW(CW), .RW(RW)) u_hit (
      .px  (x_s),
      .py  (y_s),
      .cx  (central_q[i*2*CW+CW +: CW]),
      .cy  (central_q[i*2*CW    +: CW]),
      .r   (radius_q[i*RW +: RW]),
      .hit (hit[i])
    );
  end

  // Reduce the registered hit vector to a count decision for the selected mode.
  always_comb begin
    logic [NUM_SETS-1:0] hm;
    hm = h_q & mask_q;
    count_hit = 1'b0;
    case (mode_q)
      MODE_SINGLE:      count_hit = h_q[0];
      MODE_ALL:         count_hit = (mask_q != '0) && (&(h_q | ~mask_q));
      MODE_ANY:         count_hit = |hm;
      MODE_EXACTLY_ONE: count_hit = popcount(MAX_SETS'(hm)) == 32'd1;
      MODE_ODD:         count_hit = ^hm;
      default:          count_hit = 1'b0;
    endcase
  end

  assign last_point = (x_s == CW'(GRID)) && (y_s == CW'(GRID));

  // Job FSM, scan counters, stage1 hit register and stage2 accumulator.
  // NOTE: every register here is updated with <= so the stages all sample
  // pre-edge values; blocking assignments would collapse the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      valid     <= 1'b0;
      candidate <= '0;
      x_s       <= CW'(1);
      y_s       <= CW'(1);
      h_q       <= '0;
      h_valid   <= 1'b0;
      central_q <= '0;
      radius_q  <= '0;
      mask_q    <= '0;
      mode_q    <= '0;
    end else begin
      valid   <= 1'b0;
      h_valid <= 1'b0;
      h_q     <= hit;
      if (h_valid && count_hit) begin
        candidate <= candidate + KW'(1);
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (en) begin
            central_q <= central;
            radius_q  <= radius;
            mask_q    <= set_mask;
            mode_q    <= mode;
            candidate <= '0;
            busy      <= 1'b1;
            x_s       <= CW'(1);
            y_s       <= CW'(1);
            state     <= ST_SCAN;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          h_valid <= 1'b1;
          if (last_point) begin
            x_s   <= CW'(1);
            y_s   <= CW'(1);
            state <= ST_DRAIN;
          end else if (y_s == CW'(GRID)) begin
            y_s <= CW'(1);
            x_s <= x_s + CW'(1);
          end else begin
            y_s <= y_s + CW'(1);
          end
        end
        ST_DRAIN: begin
          valid <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SET_HIT_STREAM_EN
  logic [CW-1:0] px_q;
  logic [CW-1:0] py_q;

  // Carry the scanned coordinates alongside the hit vector, then report each counted point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q      <= '0;
      py_q      <= '0;
      hit_valid <= 1'b0;
      hit_x     <= '0;
      hit_y     <= '0;
    end else begin
      px_q      <= x_s;
      py_q      <= y_s;
      hit_valid <= h_valid && count_hit;
      if (h_valid && count_hit) begin
        hit_x <= px_q;
        hit_y <= py_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_set_multi_count.sv
// Self-checking bench for set_multi_count (GRID=8, NUM_SETS=3, RW=4).
// When a job is accepted, its expected count is queued. When valid appears,
// the count is popped and compared.
module tb_set_multi_count;

  localparam int NS = 3;
  localparam int G  = 8;
  localparam int RW = 4;
  localparam int CW = 4;
  localparam int KW = 7;

  logic               clk;
  logic               rst;
  logic               en;
  logic [NS*2*CW-1:0] central;
  logic [NS*RW-1:0]   radius;
  logic [NS-1:0]      set_mask;
  logic [2:0]         mode;
  logic               busy;
  logic               valid;
  logic [KW-1:0]      candidate;
`ifdef SET_HIT_STREAM_EN
  logic               hit_valid;
  logic [CW-1:0]      hit_x;
  logic [CW-1:0]      hit_y;
`endif

  int n_checks;
  int n_pass;
  int exp_q[$];

  set_multi_count #(.NUM_SETS(NS), .GRID(G), .RW(RW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .central   (central),
    .radius    (radius),
    .set_mask  (set_mask),
    .mode      (mode),
`ifdef SET_HIT_STREAM_EN
    .hit_valid (hit_valid),
    .hit_x     (hit_x),
    .hit_y     (hit_y),
`endif
    .busy      (busy),
    .valid     (valid),
    .candidate (candidate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_cfg(input int cx0, input int cy0, input int r0,
                         input int cx1, input int cy1, input int r1,
                         input int cx2, input int cy2, input int r2,
                         input int msk, input int md);
    central  = {4'(cx2), 4'(cy2), 4'(cx1), 4'(cy1), 4'(cx0), 4'(cy0)};
    radius   = {4'(r2), 4'(r1), 4'(r0)};
    set_mask = 3'(msk);
    mode     = 3'(md);
  endtask

  // Reference count computed directly from the point-set definition.
  function automatic int model(input int cx[3], input int cy[3], input int r[3],
                               input int msk, input int md);
    int cnt;
    cnt = 0;
    for (int x = 1; x <= G; x++) begin
      for (int y = 1; y <= G; y++) begin
        int h[3];
        int sel;
        int all_in;
        int any_in;
        bit f;
        sel = 0; all_in = 1; any_in = 0;
        for (int i = 0; i < 3; i++) begin
          h[i] = ((x-cx[i])*(x-cx[i]) + (y-cy[i])*(y-cy[i]) <= r[i]*r[i]) ? 1 : 0;
          if (msk & (1 << i)) begin
            sel += h[i];
            if (h[i] == 0) all_in = 0;
            if (h[i] == 1) any_in = 1;
          end
        end
        case (md)
          0:       f = (h[0] == 1);
          1:       f = (msk != 0) && (all_in == 1);
          2:       f = (any_in == 1);
          3:       f = (sel == 1);
          4:       f = (sel % 2 == 1);
          default: f = 1'b0;
        endcase
        if (f) cnt++;
      end
    end
    return cnt;
  endfunction

  // Raise en across one rising edge (the accept edge), then scramble the inputs.
  task automatic start_job(input int exp);
    exp_q.push_back(exp);
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_valid_low", valid, 0);
    check("accept_cand_cleared", candidate, 0);
    central  = $urandom;
    radius   = $urandom;
    set_mask = 3'($urandom);
    mode     = 3'($urandom);
  endtask

  // Wait for valid with a cycle budget. A nonzero pulse_at drives a stray en at that cycle.
  task automatic wait_done(input string tag, input int pulse_at);
    int  cnt;
    bit  seen;
    int  e;
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (valid) seen = 1'b1;
      else begin
        if (cnt == pulse_at) en = 1'b1;
        if (cnt == pulse_at + 1) en = 1'b0;
      end
    end
    en = 1'b0;
    check({tag, "_latency"}, cnt, 65);
    check({tag, "_busy_low"}, busy, 0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    check({tag, "_count"}, candidate, e);
  endtask

  // One cycle after valid: the pulse has dropped and the count is held.
  task automatic after_done(input string tag, input int exp);
    @(posedge clk);
    #1;
    check({tag, "_valid_pulse"}, valid, 0);
    check({tag, "_cand_held"}, candidate, exp);
  endtask

  initial begin
    int  cx[3];
    int  cy[3];
    int  r[3];
    int  msk;
    int  md;
    int  e;
    bit  seen;

    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    en  = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("reset_busy", busy, 0);
    check("reset_valid", valid, 0);
    check("reset_cand", candidate, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // T1: single circle, radius 2 around (4,4)
    set_cfg(4, 4, 2, 1, 1, 0, 1, 1, 0, 0, 0);
    start_job(13);
    wait_done("t1", 0);
    after_done("t1", 13);

    // T2: single-point circle, full-grid circle, reserved mode
    set_cfg(1, 1, 0, 8, 8, 15, 8, 8, 15, 7, 0);
    start_job(1);
    wait_done("t2_point", 0);
    set_cfg(4, 4, 15, 1, 1, 0, 1, 1, 0, 0, 0);
    start_job(64);
    wait_done("t2_full", 0);
    set_cfg(4, 4, 15, 4, 4, 15, 4, 4, 15, 7, 5);
    start_job(0);
    wait_done("t2_reserved", 0);

    // T3: ALL / EXACTLY_ONE on identical circles, ALL with empty mask
    set_cfg(4, 4, 2, 4, 4, 2, 1, 1, 0, 3, 1);
    start_job(13);
    wait_done("t3_all", 0);
    set_cfg(4, 4, 2, 4, 4, 2, 1, 1, 0, 3, 3);
    start_job(0);
    wait_done("t3_one", 0);
    set_cfg(4, 4, 2, 4, 4, 2, 1, 1, 0, 0, 1);
    start_job(0);
    wait_done("t3_nomask", 0);

    // T4: ANY over two distinct points, ODD over three coincident points
    set_cfg(2, 2, 0, 7, 7, 0, 4, 4, 15, 3, 2);
    start_job(2);
    wait_done("t4_any", 0);
    set_cfg(5, 5, 0, 5, 5, 0, 5, 5, 0, 7, 4);
    start_job(1);
    wait_done("t4_odd", 0);

    // Randomised geometry against the reference model, centres may lie off-grid
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        cx[i] = $urandom_range(0, 15);
        cy[i] = $urandom_range(0, 15);
        r[i]  = $urandom_range(0, 6);
      end
      msk = $urandom_range(1, 7);
      md  = 1 + k * 2;
      e = model(cx, cy, r, msk, md);
      set_cfg(cx[0], cy[0], r[0], cx[1], cy[1], r[1], cx[2], cy[2], r[2], msk, md);
      start_job(e);
      wait_done("rand", 0);
    end

    // T5: en while busy is ignored, en in the valid cycle starts a new job
    set_cfg(4, 4, 2, 1, 1, 0, 1, 1, 0, 0, 0);
    start_job(13);
    wait_done("t5_ignored", 10);
    set_cfg(4, 4, 15, 1, 1, 0, 1, 1, 0, 0, 0);
    start_job(64);
    wait_done("t5_chain", 0);
    after_done("t5_chain", 64);

    // T6: asynchronous reset mid-job aborts with no valid
    set_cfg(4, 4, 2, 1, 1, 0, 1, 1, 0, 0, 0);
    start_job(13);
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_valid", valid, 0);
    check("t6_abort_cand", candidate, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(posedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    check("t6_no_valid", seen, 0);
    set_cfg(4, 4, 2, 1, 1, 0, 1, 1, 0, 0, 0);
    start_job(13);
    wait_done("t6_next", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
